regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised architectural register file with an integrated per-register scoreboard for the pipelined core. It provides two asynchronous read ports, one synchronous writeback port, an issue port that marks destination registers busy, and a registered pending-writes counter. It also provides a debug tap on one fixed register. It replaces the fixed 32x32 register file in the decode/writeback stages and feeds hazard detection directly.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, register count; power of two, ≥ 4; AW = log2(NREGS)
- SP_IDX, 2, index loaded with SP_INIT on reset
- SP_INIT, 32'h2ffc, stack pointer reset value (XLEN bits)
- DBG_IDX, 17, register mirrored on dbg_dout

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rs1, rs2  in  AW  read addresses
- rs1_dout, rs2_dout  out  XLEN  read data
- rs1_busy, rs2_busy  out  1  scoreboard bit of the addressed register
- wr_en  in  1  writeback strobe
- wr_rd  in  AW  writeback destination
- wr_data  in  XLEN  writeback data
- issue_en  in  1  instruction issued with a destination
- issue_rd  in  AW  destination to mark busy
- flush  in  1  clear all busy bits (pipeline squash)
- pending_cnt  out  AW+1  number of busy registers, registered
- dbg_dout  out  XLEN  combinational copy of rf[DBG_IDX]

## Operation
- Register 0:
  - Reads as 0.
  - Never written.
  - Never busy; issue or writeback to index 0 is ignored entirely.
- Reads are combinational from rf and busy[]. The bypass behaviour is described under Configuration.
- Writeback with wr_en=1 and wr_rd≠0 writes rf[wr_rd]<=wr_data and clears busy[wr_rd].
- Issue with issue_en=1 and issue_rd≠0 sets busy[issue_rd].
- Issue and writeback to the same rd in the same cycle:
  - Data is written.
  - busy stays/becomes 1, because the new producer wins.
- flush=1 clears every busy bit and sets pending_cnt to 0.
  - flush overrides issue and writeback-clear in the same cycle.
  - The writeback data write still occurs.
- pending_cnt tracks popcount(busy) incrementally:
  - +1 when issue hits a non-busy register.
  - −1 when writeback clears a busy register that is not being re-issued.
  - Net 0 for both events on different registers in the same cycle.
  - Issue to an already-busy register (WAW) leaves the count unchanged.
  - Writeback to a non-busy register leaves the count unchanged.
- pending_cnt never exceeds NREGS−1 by construction. The bench asserts pending_cnt == popcount(busy) every cycle.

## Timing
- Reset, at the clk edge with reset=1:
  - All rf entries are set to 0, except rf[SP_IDX]=SP_INIT.
  - All busy bits are cleared and pending_cnt=0.
  - reset overrides wr_en, issue_en and flush.
  - A mid-operation reset discards all in-flight busy state.
- Post-reset outputs:
  - rs*_dout = 0, except a read of SP_IDX, which returns SP_INIT.
  - rs*_busy = 0.
  - dbg_dout = 0, unless DBG_IDX==SP_IDX.
  - pending_cnt = 0.
- Read latency is 0 cycles (combinational).
- Write and busy updates are visible the cycle after the edge, unless bypass applies.
- Issue at edge N: rs*_busy reads 1 from cycle N+1.
- Writeback at edge N: busy reads 0 and data is new from cycle N+1.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose address equals wr_rd, with wr_en=1 and wr_rd≠0, returns wr_data in the same cycle.
  - The corresponding rs*_busy reads 0 that cycle, unless issue_en targets the same register in the same cycle.
  - dbg_dout is not bypassed.
- REGFILE_BYPASS_EN undefined:
  - Reads return stored rf/busy values only.
  - Same-cycle write data appears the next cycle; consumers must stall one cycle.

## Test plan
- Reset then read all indices:
  - rs1 of reg 2 = 32'h2ffc; every other register = 0.
  - pending_cnt=0; all busy=0.
- Issue x5, then writeback x5=32'hDEADBEEF two cycles later:
  - rs1_busy=1 for two cycles, then 0 with data DEADBEEF.
  - pending_cnt goes 0→1→0.
- Same-cycle issue x7 and writeback x7=32'h1234:
  - rf[7]=0x1234 next cycle.
  - busy[7]=1; pending_cnt=1.
- Write x0=32'hFFFFFFFF and issue x0:
  - rs2 of x0 reads 0; busy 0; pending_cnt 0.
- Issue x3, x4, x9, then flush together with a writeback to x4:
  - pending_cnt 3→0.
  - rf[4] updated; all busy 0.
- With REGFILE_BYPASS_EN, writeback x17=0xA5A5A5A5 while rs1=17:
  - rs1_dout=0xA5A5A5A5 the same cycle.
  - dbg_dout updates only the next cycle.
  - Without the macro, rs1_dout shows the old value that cycle.

Source files
------------

// File: rtl/regfile_sb.sv
// Architectural register file with per-register busy scoreboard and pending-writes counter.
// Optional same-cycle writeback forwarding on the read ports: define REGFILE_BYPASS_EN.
module regfile_sb #(
   parameter int XLEN = 32,
   parameter int NREGS = 32,
   parameter int SP_IDX = 2,
   parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h2ffc),
   parameter int DBG_IDX = 17,
   localparam int AW = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rs1_dout,
   output logic [XLEN-1:0] rs2_dout,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_rd,
   input  logic [XLEN-1:0] wr_data,
   input  logic            issue_en,
   input  logic [AW-1:0]   issue_rd,
   input  logic            flush,
   output logic [AW:0]     pending_cnt,
   output logic [XLEN-1:0] dbg_dout
);

   logic [XLEN-1:0] rf_reg [NREGS];
   logic [NREGS-1:0] busy_reg;
   logic [NREGS-1:0] busy_next;
   logic [AW:0] cnt_reg;
   logic [AW:0] cnt_next;
   logic issue_hit;
   logic wb_hit;
   logic cnt_inc;
   logic cnt_dec;

   // Register 0 is excluded here, so it is never written and never marked busy.
   assign issue_hit = issue_en && (issue_rd != '0);
   assign wb_hit    = wr_en && (wr_rd != '0);

   // A writeback only retires a pending entry if the same cycle does not re-issue it.
   assign cnt_inc = issue_hit && !busy_reg[issue_rd];
   assign cnt_dec = wb_hit && busy_reg[wr_rd] && !(issue_hit && (issue_rd == wr_rd));

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
         localparam logic [AW-1:0] IDX = AW'(gi);
         assign busy_next[gi] = flush                           ? 1'b0 :
                                (issue_hit && issue_rd == IDX)  ? 1'b1 :
                                (wb_hit && wr_rd == IDX)        ? 1'b0 :
                                busy_reg[gi];
      end
   endgenerate

   always_comb begin
      cnt_next = cnt_reg;
      if (flush) begin
         cnt_next = '0;
      end else if (cnt_inc && !cnt_dec) begin
         cnt_next = cnt_reg + (AW+1)'(1);
      end else if (!cnt_inc && cnt_dec) begin
         cnt_next = cnt_reg - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_reg <= '0;
         cnt_reg  <= '0;
         for (int i = 0; i < NREGS; i++) begin
            rf_reg[i] <= (i == SP_IDX) ? SP_INIT : '0;
         end
      end else begin
         busy_reg <= busy_next;
         cnt_reg  <= cnt_next;
         if (wb_hit) begin
            rf_reg[wr_rd] <= wr_data;
         end
      end
   end

   assign pending_cnt = cnt_reg;
   assign dbg_dout    = rf_reg[DBG_IDX];

`ifdef REGFILE_BYPASS_EN
   logic rs1_fwd;
   logic rs2_fwd;

   assign rs1_fwd = wb_hit && (wr_rd == rs1);
   assign rs2_fwd = wb_hit && (wr_rd == rs2);

   // A forwarded read is free unless the same register is re-issued this cycle.
   always_comb begin
      rs1_dout = rs1_fwd ? wr_data : rf_reg[rs1];
      rs2_dout = rs2_fwd ? wr_data : rf_reg[rs2];
      rs1_busy = rs1_fwd ? (issue_hit && issue_rd == rs1) : busy_reg[rs1];
      rs2_busy = rs2_fwd ? (issue_hit && issue_rd == rs2) : busy_reg[rs2];
   end
`else
   always_comb begin
      rs1_dout = rf_reg[rs1];
      rs2_dout = rf_reg[rs2];
      rs1_busy = busy_reg[rs1];
      rs2_busy = busy_reg[rs2];
   end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table with scoreboard queue plus corner sequences.
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1, rs2;
   logic [31:0] rs1_dout, rs2_dout;
   logic        rs1_busy, rs2_busy;
   logic        wr_en;
   logic [4:0]  wr_rd;
   logic [31:0] wr_data;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic        flush;
   logic [5:0]  pending_cnt;
   logic [31:0] dbg_dout;

   int n_tests = 0;
   int n_fail  = 0;
   logic chk_on = 1'b0;
   logic [31:0] mbusy = '0;

   regfile_sb dut (
      .clk(clk), .reset(reset),
      .rs1(rs1), .rs2(rs2),
      .rs1_dout(rs1_dout), .rs2_dout(rs2_dout),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
      .issue_en(issue_en), .issue_rd(issue_rd),
      .flush(flush),
      .pending_cnt(pending_cnt),
      .dbg_dout(dbg_dout)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        we;
      logic [4:0]  wrd;
      logic [31:0] wd;
      logic        ie;
      logic [4:0]  ird;
      logic        fl;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [31:0] e1;
      logic        e1b;
      logic [31:0] e2;
      logic        e2b;
      logic [5:0]  ecnt;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] e1;
      logic        e1b;
      logic [31:0] e2;
      logic        e2b;
      logic [5:0]  ecnt;
   } exp_t;

   vec_t vecs [16];
   exp_t sb_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Behavioural busy model: writeback clears, issue sets (new producer wins), flush clears all.
   function automatic logic [31:0] next_busy(input logic [31:0] b);
      logic [31:0] n;
      n = b;
      if (wr_en && wr_rd != 5'd0) n[wr_rd] = 1'b0;
      if (issue_en && issue_rd != 5'd0) n[issue_rd] = 1'b1;
      if (flush) n = '0;
      return n;
   endfunction

   always @(posedge clk) begin
      if (reset) mbusy <= '0;
      else       mbusy <= next_busy(mbusy);
   end

   always @(negedge clk) begin
      if (chk_on) chk("cnt_eq_popcount", {26'd0, pending_cnt}, $countones(mbusy));
   end

   task automatic idle_inputs();
      wr_en = 1'b0; wr_rd = '0; wr_data = '0;
      issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      reset = 1'b1; rs1 = '0; rs2 = '0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk_on = 1'b1;
      #1;
      chk("rst_cnt", {26'd0, pending_cnt}, 32'd0);
      chk("rst_dbg", dbg_dout, 32'd0);
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i); rs2 = 5'(31 - i);
         #1;
         chk($sformatf("rst_rs1_x%0d", i), rs1_dout, (i == 2) ? 32'h2ffc : 32'd0);
         chk($sformatf("rst_rs2_x%0d", 31 - i), rs2_dout, (31 - i == 2) ? 32'h2ffc : 32'd0);
         chk($sformatf("rst_busy_x%0d", i), {30'd0, rs1_busy, rs2_busy}, 32'd0);
      end

      //          name      we wrd wd            ie ird fl r1 r2  e1            e1b e2            e2b cnt
      vecs[0]  = '{"iss5",   0, 0, 0,            1, 5,  0, 5, 2,  0,            1,  32'h2ffc,     0,  1};
      vecs[1]  = '{"hold5",  0, 0, 0,            0, 0,  0, 5, 5,  0,            1,  0,            1,  1};
      vecs[2]  = '{"wb5",    1, 5, 32'hDEADBEEF, 0, 0,  0, 5, 5,  32'hDEADBEEF, 0,  32'hDEADBEEF, 0,  0};
      vecs[3]  = '{"isswb7", 1, 7, 32'h1234,     1, 7,  0, 7, 0,  32'h1234,     1,  0,            0,  1};
      vecs[4]  = '{"x0",     1, 0, 32'hFFFFFFFF, 1, 0,  0, 7, 0,  32'h1234,     1,  0,            0,  1};
      vecs[5]  = '{"wb7",    1, 7, 32'h77,       0, 0,  0, 7, 5,  32'h77,       0,  32'hDEADBEEF, 0,  0};
      vecs[6]  = '{"iss3",   0, 0, 0,            1, 3,  0, 3, 7,  0,            1,  32'h77,       0,  1};
      vecs[7]  = '{"iss4",   0, 0, 0,            1, 4,  0, 4, 3,  0,            1,  0,            1,  2};
      vecs[8]  = '{"iss9",   0, 0, 0,            1, 9,  0, 9, 4,  0,            1,  0,            1,  3};
      vecs[9]  = '{"waw3",   0, 0, 0,            1, 3,  0, 3, 9,  0,            1,  0,            1,  3};
      vecs[10] = '{"wbfree", 1, 10, 32'hAA,      0, 0,  0, 10, 3, 32'hAA,       0,  0,            1,  3};
      vecs[11] = '{"flush",  1, 4, 32'h4444,     1, 9,  1, 4, 9,  32'h4444,     0,  0,            0,  0};
      vecs[12] = '{"iss12",  0, 0, 0,            1, 12, 0, 12, 3, 0,            1,  0,            0,  1};
      vecs[13] = '{"net0",   1, 12, 32'hC,       1, 13, 0, 12, 13, 32'hC,       0,  0,            1,  1};
      vecs[14] = '{"wb13",   1, 13, 32'hD,       0, 0,  0, 13, 12, 32'hD,       0,  32'hC,        0,  0};
      vecs[15] = '{"iss17",  0, 0, 0,            1, 17, 0, 17, 2, 0,            1,  32'h2ffc,     0,  1};

      for (int k = 0; k < 16; k++) begin
         wr_en = vecs[k].we; wr_rd = vecs[k].wrd; wr_data = vecs[k].wd;
         issue_en = vecs[k].ie; issue_rd = vecs[k].ird; flush = vecs[k].fl;
         rs1 = vecs[k].r1; rs2 = vecs[k].r2;
         sb_q.push_back('{vecs[k].name, vecs[k].e1, vecs[k].e1b, vecs[k].e2, vecs[k].e2b, vecs[k].ecnt});
         @(posedge clk);
         #1 idle_inputs();
         #1;
         e = sb_q.pop_front();
         chk({e.name, "_rs1"}, rs1_dout, e.e1);
         chk({e.name, "_rs1b"}, {31'd0, rs1_busy}, {31'd0, e.e1b});
         chk({e.name, "_rs2"}, rs2_dout, e.e2);
         chk({e.name, "_rs2b"}, {31'd0, rs2_busy}, {31'd0, e.e2b});
         chk({e.name, "_cnt"}, {26'd0, pending_cnt}, {26'd0, e.ecnt});
      end

      // Same-cycle writeback to x17 while reading it: forwarded only with bypass.
      wr_en = 1'b1; wr_rd = 5'd17; wr_data = 32'hA5A5A5A5; rs1 = 5'd17;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp_rs1", rs1_dout, 32'hA5A5A5A5);
      chk("byp_rs1b", {31'd0, rs1_busy}, 32'd0);
`else
      chk("byp_rs1", rs1_dout, 32'd0);
      chk("byp_rs1b", {31'd0, rs1_busy}, 32'd1);
`endif
      chk("byp_dbg_same", dbg_dout, 32'd0);
      @(posedge clk);
      #1 idle_inputs();
      #1;
      chk("byp_dbg_next", dbg_dout, 32'hA5A5A5A5);
      chk("byp_rs1_next", rs1_dout, 32'hA5A5A5A5);
      chk("byp_cnt_next", {26'd0, pending_cnt}, 32'd0);

      // Forwarded writeback re-issued in the same cycle keeps the register busy.
      wr_en = 1'b1; wr_rd = 5'd17; wr_data = 32'h1; issue_en = 1'b1; issue_rd = 5'd17;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypiss_rs1", rs1_dout, 32'h1);
      chk("bypiss_rs1b", {31'd0, rs1_busy}, 32'd1);
`else
      chk("bypiss_rs1", rs1_dout, 32'hA5A5A5A5);
      chk("bypiss_rs1b", {31'd0, rs1_busy}, 32'd0);
`endif
      @(posedge clk);
      #1 idle_inputs();
      #1;
      chk("bypiss_rs1_next", rs1_dout, 32'h1);
      chk("bypiss_busy_next", {31'd0, rs1_busy}, 32'd1);
      chk("bypiss_dbg_next", dbg_dout, 32'h1);

      // Mid-operation reset discards busy state and overrides a concurrent write/issue.
      issue_en = 1'b1; issue_rd = 5'd20;
      @(posedge clk);
      #1 idle_inputs();
      #1 chk("pre_rst_cnt", {26'd0, pending_cnt}, 32'd2);
      reset = 1'b1; wr_en = 1'b1; wr_rd = 5'd21; wr_data = 32'h21;
      issue_en = 1'b1; issue_rd = 5'd22; rs1 = 5'd21; rs2 = 5'd20;
      @(posedge clk);
      #1 reset = 1'b0; idle_inputs();
      #1;
      chk("mrst_rs1", rs1_dout, 32'd0);
      chk("mrst_busy", {30'd0, rs1_busy, rs2_busy}, 32'd0);
      chk("mrst_cnt", {26'd0, pending_cnt}, 32'd0);
      rs1 = 5'd2; rs2 = 5'd5;
      #1;
      chk("mrst_sp", rs1_dout, 32'h2ffc);
      chk("mrst_x5", rs2_dout, 32'd0);
      rs1 = 5'd22; rs2 = 5'd17;
      #1;
      chk("mrst_busy22_17", {30'd0, rs1_busy, rs2_busy}, 32'd0);
      chk("mrst_dbg", dbg_dout, 32'd0);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
